// File: rtl/stc0_pkg.sv
// stc0_pkg: shared definitions for the stc0 ingress path.
//   BYTE_W / BYTES_PER_WORD describe the word-to-byte serialisation,
//   ser_state_e is the serializer state encoding.
package stc0_pkg;
  localparam int BYTE_W         = 8;
  localparam int BYTES_PER_WORD = 4;
  localparam int WORD_W         = BYTE_W * BYTES_PER_WORD;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAPW = 2'd2
  } ser_state_e;
endpackage

// File: rtl/stc0_fifo.sv
// stc0_fifo: synchronous single-clock FIFO with a registered occupancy count.
//   clk, rst_n : clock, asynchronous active-low reset
//   wr_en      : push request; ignored while full
//   wr_data    : word to push
//   rd_en      : pop request; ignored while empty
//   rd_data    : head word (combinational read of the head slot)
//   level      : registered occupancy, 0..DEPTH
module stc0_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic [AW:0]      level
);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q, level_d;
  logic             do_push, do_pop;

  // Fullness comes from the registered level only, so a pop on the same
  // edge never frees a slot for a push.
  assign do_push = wr_en && (level_q != FULL_LVL);
  assign do_pop  = rd_en && (level_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;  // DEPTH is a power of two: wraps
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage needs no reset: a slot is only read after it has been written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data;
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign level   = level_q;
endmodule

// File: rtl/stc0_ingress_tx.sv
// stc0_ingress_tx: buffers 32-bit words and serialises them MSB byte first
// onto the stc0 core ingress byte stream, with GAP idle cycles after each word.
//   ClkIngress, ARstN : clock, asynchronous active-low reset
//   Enable            : allows new words to start on the byte side
//   WData/WValid/WReady : word input handshake
//   ID/IValid         : byte stream out (ID is 0 whenever IValid is 0)
//   Level             : FIFO occupancy
//   Busy              : serializer in SEND or GAPW
//   WordCount         : fully transmitted words, wraps at 16 bits
module stc0_ingress_tx
  import stc0_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int GAP   = 0
) (
  input  logic                     ClkIngress,
  input  logic                     ARstN,
  input  logic                     Enable,
  input  logic [31:0]              WData,
  input  logic                     WValid,
  output logic                     WReady,
  output logic [7:0]               ID,
  output logic                     IValid,
  output logic [$clog2(DEPTH):0]   Level,
  output logic                     Busy,
  output logic [15:0]              WordCount
);
  localparam int          LW        = $clog2(DEPTH) + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
  localparam logic [3:0]  GAP_LAST  = 4'((GAP > 0) ? GAP - 1 : 0);
  localparam logic [2:0]  LAST_BYTE = 3'(BYTES_PER_WORD - 1);

  ser_state_e        state_q, state_d;
  logic [WORD_W-1:0] shreg_q, shreg_d;
  logic [2:0]        byte_idx_q, byte_idx_d;
  logic [3:0]        gap_cnt_q, gap_cnt_d;
  logic [15:0]       word_cnt_q, word_cnt_d;

  logic              pop;
  logic [WORD_W-1:0] fifo_rdata;
  logic [LW-1:0]     fifo_level;
  logic              can_start;

  stc0_fifo #(.WIDTH(WORD_W), .DEPTH(DEPTH)) u_fifo (
    .clk     (ClkIngress),
    .rst_n   (ARstN),
    .wr_en   (WValid),
    .wr_data (WData),
    .rd_en   (pop),
    .rd_data (fifo_rdata),
    .level   (fifo_level)
  );

  assign can_start = (fifo_level != '0) && Enable;

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    byte_idx_d = byte_idx_q;
    gap_cnt_d  = gap_cnt_q;
    word_cnt_d = word_cnt_q;
    pop        = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (can_start) begin
          pop        = 1'b1;
          shreg_d    = fifo_rdata;
          byte_idx_d = '0;
          state_d    = SEND;
        end
      end
      SEND: begin
        // Enable is only looked at between words, so a word always completes.
        shreg_d    = shreg_q << BYTE_W;
        byte_idx_d = byte_idx_q + 3'd1;
        if (byte_idx_q == LAST_BYTE) begin
          word_cnt_d = word_cnt_q + 16'd1;
          byte_idx_d = '0;
          if (GAP > 0) begin
            gap_cnt_d = '0;
            state_d   = GAPW;
          end else if (can_start) begin
            // Chain straight into the next word so IValid stays high.
            pop     = 1'b1;
            shreg_d = fifo_rdata;
          end else begin
            state_d = IDLE;
          end
        end
      end
      GAPW: begin
        if (gap_cnt_q == GAP_LAST) begin
          // Leaving the gap directly into SEND keeps the idle run between
          // queued words at exactly GAP cycles; otherwise park in IDLE.
          if (can_start) begin
            pop        = 1'b1;
            shreg_d    = fifo_rdata;
            byte_idx_d = '0;
            state_d    = SEND;
          end else begin
            state_d = IDLE;
          end
        end else begin
          gap_cnt_d = gap_cnt_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ClkIngress or negedge ARstN) begin
    if (!ARstN) begin
      state_q    <= IDLE;
      shreg_q    <= '0;
      byte_idx_q <= '0;
      gap_cnt_q  <= '0;
      word_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      byte_idx_q <= byte_idx_d;
      gap_cnt_q  <= gap_cnt_d;
      word_cnt_q <= word_cnt_d;
    end
  end

  // Outputs decode registered state only; the async reset clears them at once.
  assign IValid    = (state_q == SEND);
  assign ID        = IValid ? shreg_q[WORD_W-1 -: BYTE_W] : '0;
  assign Busy      = (state_q != IDLE);
  assign WReady    = (fifo_level != FULL_LVL);
  assign Level     = fifo_level;
  assign WordCount = word_cnt_q;
endmodule
